pll_phase_ctrl: RTL and testbench

Controller for an ECP5 EHXPLLL instance with dynamic phase adjustment. It supervises PLL lock and generates a debounced downstream reset. It also accepts phase-shift requests of the form "move output X by N steps, direction D" over a valid/ready handshake, then drives the PLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG pins with the required setup, pulse and gap timing. It runs in the PLL reference-clock domain (25 MHz board clock) and sits between the PLL wrapper and the design's clock/reset fabric.

---
 rtl/pll_ctrl_pkg.sv | 27 ++
 rtl/lock_supervisor.sv | 52 +++++
 rtl/pll_phase_ctrl.sv | 152 +++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL phase controller: FSM encoding,
// PHASESEL output selects, PHASEDIR directions and a sizing helper.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

    // Largest of three timing parameters, used to size the shared timing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_supervisor.sv
// PLL lock supervisor: synchronizes LOCK, requires LOCK_CYC consecutive
// locked cycles, and produces a registered active-high downstream reset.
module lock_supervisor #(
    parameter int LOCK_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic locked_i,
    output logic lock_s_o,
    output logic lock_ok_next_o,
    output logic rst_out_o
);

    localparam int LW = $clog2(LOCK_CYC + 1);

    logic          meta_q;
    logic          lock_s_q;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic          rst_out_q;

    // Saturating lock counter; any unlocked cycle restarts the qualification.
    always_comb begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
            cnt_d = '0;
        end else if (cnt_q != LW'(LOCK_CYC)) begin
            cnt_d = cnt_q + LW'(1);
        end
    end

    assign lock_ok_next_o = (cnt_d == LW'(LOCK_CYC));

    // Two-flop synchronizer, counter and reset register (rst_out tracks the counter value).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q    <= 1'b0;
            lock_s_q  <= 1'b0;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
        end else begin
            meta_q    <= locked_i;
            lock_s_q  <= meta_q;
            cnt_q     <= cnt_d;
            rst_out_q <= !lock_ok_next_o;
        end
    end

    assign lock_s_o  = lock_s_q;
    assign rst_out_o = rst_out_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic phase controller: accepts phase-shift requests and
// sequences PHASESEL/PHASEDIR/PHASESTEP with setup, pulse and gap timing,
// aborting on lock loss.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_CYC  = 1024,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       phaseloadreg,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rst_out
);

    localparam int TW = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

    logic          lock_s;
    logic          lock_ok_d;

    state_t        state_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    steps_q;
    logic [1:0]    sel_q;
    logic          dir_q;
    logic          step_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          ready_q;

    lock_supervisor #(
        .LOCK_CYC(LOCK_CYC)
    ) u_lock (
        .clk_i         (clock),
        .rst_i         (reset),
        .locked_i      (locked),
        .lock_s_o      (lock_s),
        .lock_ok_next_o(lock_ok_d),
        .rst_out_o     (rst_out)
    );

    // Phase-step sequencer; req_ready is registered from the next state and next lock status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            steps_q <= '0;
            sel_q   <= SEL_CLKOP;
            dir_q   <= DIR_DELAY;
            step_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != ST_IDLE && !lock_s) begin
                state_q <= ST_IDLE;
                tcnt_q  <= '0;
                steps_q <= '0;
                step_q  <= 1'b1;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                ready_q <= lock_ok_d;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_valid && ready_q) begin
                            if (req_steps == 8'd0) begin
                                done_q  <= 1'b1;
                                ready_q <= lock_ok_d;
                            end else begin
                                state_q <= ST_SETUP;
                                sel_q   <= req_sel;
                                dir_q   <= req_dir;
                                steps_q <= req_steps;
                                tcnt_q  <= '0;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            ready_q <= lock_ok_d;
                        end
                    end
                    ST_SETUP: begin
                        if (tcnt_q == TW'(SETUP_CYC - 1)) begin
                            state_q <= ST_PULSE;
                            step_q  <= 1'b0;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (tcnt_q == TW'(PULSE_CYC - 1)) begin
                            state_q <= ST_GAP;
                            step_q  <= 1'b1;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (tcnt_q == TW'(GAP_CYC - 1)) begin
                            tcnt_q <= '0;
                            if (steps_q == 8'd1) begin
                                state_q <= ST_IDLE;
                                steps_q <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                ready_q <= lock_ok_d;
                            end else begin
                                state_q <= ST_PULSE;
                                steps_q <= steps_q - 8'd1;
                                step_q  <= 1'b0;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign req_ready    = ready_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = 1'b1;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed testbench for pll_phase_ctrl with a completion scoreboard.
module tb_pll_phase_ctrl;

    localparam int LOCK_CYC  = 16;
    localparam int SETUP_CYC = 2;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 4;
    localparam int PER       = PULSE_CYC + GAP_CYC;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel = 2'd0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;
    logic       busy;
    logic       done;
    logic       err;
    logic       rst_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        bit is_err;
        int cyc;
    } exp_t;
    exp_t sb[$];

    pll_phase_ctrl #(
        .LOCK_CYC (LOCK_CYC),
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .phasesel    (phasesel),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .phaseloadreg(phaseloadreg),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rst_out     (rst_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (done === 1'b1 || err === 1'b1) begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'({done, err}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", 32'({done, err}), e.is_err ? 32'd1 : 32'd2);
                chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic bit exp_step(input int i, input int n);
        int j;
        if (i <= SETUP_CYC) return 1'b1;
        j = i - SETUP_CYC - 1;
        if (j >= n * PER) return 1'b1;
        return (j % PER) >= PULSE_CYC;
    endfunction

    // Drive a request in the current cycle (cycle 0); optionally expect its done.
    task automatic issue(input logic [1:0] sel, input logic dir, input int steps, input bit push);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = 8'(steps);
        if (push) begin
            if (steps == 0) sb.push_back('{1'b0, cyc + 1});
            else            sb.push_back('{1'b0, cyc + SETUP_CYC + steps * PER + 1});
        end
    endtask

    // Walk cycles 1..stop of an accepted sequence, checking the pin outputs.
    task automatic trace_seq(input logic [1:0] sel, input logic dir, input int n, input int stop,
                             input bit keep, input logic [1:0] a_sel, input logic a_dir,
                             input int a_steps, input int drop_at);
        int total;
        total = (n == 0) ? 1 : SETUP_CYC + n * PER + 1;
        for (int i = 1; i <= stop; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                if (keep) begin
                    req_sel   = a_sel;
                    req_dir   = a_dir;
                    req_steps = 8'(a_steps);
                end else begin
                    req_valid = 1'b0;
                end
            end
            chk($sformatf("seq_c%0d", i), 32'({busy, phasestep, phasesel, phasedir}),
                32'({(n > 0 && i < total), exp_step(i, n), sel, dir}));
            if (i == total) chk("ready_at_done", 32'(req_ready), 32'd1);
            if (i == drop_at) locked = 1'b0;
        end
    endtask

    // Count edges from now until rst_out deasserts, bounded.
    task automatic lock_wait(input string tag);
        int  k;
        logic rdy_before;
        rdy_before = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (rst_out == 1'b0) break;
            rdy_before = req_ready;
        end
        chk({tag, "_latency"}, 32'(k), 32'(LOCK_CYC + 2));
        chk({tag, "_ready_before"}, 32'(rdy_before), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_state",
            32'({rst_out, req_ready, busy, done, err, phasestep, phaseloadreg, phasesel, phasedir}),
            32'b1000011000);
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: lock qualification
        lock_wait("lock1");

        // 2: three-step advance on CLKOS
        issue(2'd1, 1'b1, 3, 1'b1);
        trace_seq(2'd1, 1'b1, 3, SETUP_CYC + 3 * PER + 1, 1'b0, 2'd0, 1'b0, 0, 0);

        // 3: zero-step request completes immediately, outputs held
        issue(2'd2, 1'b0, 0, 1'b1);
        trace_seq(2'd1, 1'b1, 0, 1, 1'b0, 2'd0, 1'b0, 0, 0);

        // 5: held request with different select is ignored until the done cycle
        issue(2'd2, 1'b0, 1, 1'b1);
        trace_seq(2'd2, 1'b0, 1, SETUP_CYC + PER + 1, 1'b1, 2'd3, 1'b1, 2, 0);
        sb.push_back('{1'b0, cyc + SETUP_CYC + 2 * PER + 1});
        trace_seq(2'd3, 1'b1, 2, SETUP_CYC + 2 * PER + 1, 1'b0, 2'd0, 1'b0, 0, 0);

        // 4: lock lost during the second pulse of a five-step request
        issue(2'd0, 1'b0, 5, 1'b0);
        sb.push_back('{1'b1, cyc + SETUP_CYC + PER + 1 + 3});
        trace_seq(2'd0, 1'b0, 5, SETUP_CYC + PER + 3, 1'b0, 2'd0, 1'b0, 0, SETUP_CYC + PER + 1);
        @(posedge clock); #1;
        chk("abort_state", 32'({busy, phasestep, rst_out, req_ready}), 32'b0110);
        locked = 1'b1;
        lock_wait("relock");

        // 6: asynchronous reset in the middle of a pulse
        issue(2'd1, 1'b0, 2, 1'b1);
        for (int i = 1; i <= SETUP_CYC + 1; i++) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
        end
        chk("pulse_before_reset", 32'(phasestep), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'({busy, phasestep, rst_out, req_ready, phasesel}), 32'b011000);
        void'(sb.pop_back());
        @(posedge clock); #1;
        reset = 1'b0;
        lock_wait("post_reset");

        repeat (4) @(posedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
